// File: rtl/main_mem_responder.sv
// rtl/main_mem_responder.sv - main-memory responder with pipelined single and burst reads
module main_mem_responder #(
    parameter int LATENCY   = 4,
    parameter int ADDR_W    = 16,
    parameter int DEPTH_W   = 15,
    parameter int BLK_WORDS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              wr,
    input  logic              burst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       data_in,
    output logic [15:0]       data_out,
    output logic [ADDR_W-1:0] data_addr,
    output logic              data_valid,
    output logic              busy
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W-5:0] base_q, base_d;

    logic              accept;
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_addr;
    logic [15:0]       issue_data;

    logic [15:0]       mem [0:(1<<DEPTH_W)-1];

    logic              pipe_v [LATENCY];
    logic [ADDR_W-1:0] pipe_a [LATENCY];
    logic [15:0]       pipe_d [LATENCY];

    // byte-select bit of the request address carries no information
    logic unused_addr_lsb;
    assign unused_addr_lsb = addr[0];

    assign busy   = (state_q == BURST);
    assign accept = enable && !busy;

    // Burst sequencer and issue-slot selection: burst words take the slot while busy
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        base_d      = base_q;
        issue_valid = 1'b0;
        issue_addr  = '0;
        case (state_q)
            IDLE: begin
                if (accept && !wr) begin
                    issue_valid = 1'b1;
                    if (burst) begin
                        // word 0 issues in the accept cycle, the rest follow from BURST
                        issue_addr = {addr[ADDR_W-1:4], 4'h0};
                        base_d     = addr[ADDR_W-1:4];
                        cnt_d      = 3'd1;
                        state_d    = BURST;
                    end else begin
                        issue_addr = {addr[ADDR_W-1:1], 1'b0};
                    end
                end
            end
            BURST: begin
                issue_valid = 1'b1;
                issue_addr  = {base_q, cnt_q, 1'b0};
                cnt_d       = cnt_q + 3'd1;
                if (cnt_q == 3'(BLK_WORDS - 1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Read-at-issue: data is captured when the read enters the pipeline
    assign issue_data = mem[issue_addr[DEPTH_W:1]];

    // FSM state, burst word counter and block base
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
        end
    end

    // Word array: writes commit on the accepting edge; contents survive reset
    always_ff @(posedge clk) begin
        if (rst_n && accept && wr) begin
            mem[addr[DEPTH_W:1]] <= data_in;
        end
    end

    // Fixed-latency return pipeline; reset discards every in-flight read
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe_v[i] <= 1'b0;
                pipe_a[i] <= '0;
                pipe_d[i] <= '0;
            end
        end else begin
            pipe_v[0] <= issue_valid;
            pipe_a[0] <= issue_valid ? issue_addr : '0;
            pipe_d[0] <= issue_valid ? issue_data : '0;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_a[i] <= pipe_a[i-1];
                pipe_d[i] <= pipe_d[i-1];
            end
        end
    end

    assign data_valid = pipe_v[LATENCY-1];
    assign data_out   = pipe_v[LATENCY-1] ? pipe_d[LATENCY-1] : '0;
    assign data_addr  = pipe_v[LATENCY-1] ? pipe_a[LATENCY-1] : '0;

endmodule
